// File: rtl/ocarina_song_matcher.sv
// ocarina_song_matcher
//   Recognises short melodies played on four active-low push-buttons.
//   Each button is synchronised, edge-detected, and turned into a note event.
//   A candidate mask narrows the set of songs that still agree with the notes
//   played so far. The attempt ends in MATCH when a song is completed, or in
//   FAIL on a wrong note, an invalid chord, or an idle timeout. Either result
//   is shown for HOLD_CYC cycles before the matcher returns to IDLE.
//
// Ports
//   clk        : system clock, all registers on the rising edge
//   resetn     : synchronous, active-low reset
//   key_n[3:0] : raw asynchronous buttons, active-low; bit index = note code
//   busy       : high while an attempt is in progress (LISTEN)
//   match      : high while a recognised song is displayed (MATCH)
//   match_id   : index of the most recently recognised song
//   fail       : high while a failed attempt is displayed (FAIL)
//   note_count : notes accepted in the current attempt
module ocarina_song_matcher #(
  parameter int NUM_SONGS = 4,
  parameter int MAX_LEN = 8,
  parameter logic [NUM_SONGS*MAX_LEN*2-1:0] SONG_PAT = 64'h0034_0024_001B_001E,
  parameter logic [NUM_SONGS*4-1:0] SONG_LEN = {NUM_SONGS{4'd3}},
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic [3:0] key_n,
  output logic busy,
  output logic match,
  output logic [((NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1)-1:0] match_id,
  output logic fail,
  output logic [3:0] note_count
);

  localparam int MID_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    MATCH  = 2'd2,
    FAIL   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: two synchroniser flops plus a previous-value flop.
  // All reset to 1 (released), so a key that is up at reset exit never
  // produces a spurious press.
  // ---------------------------------------------------------------------
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] prev_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
      prev_reg  <= 4'hF;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Press = high-to-low transition of the synchronised level.
  logic [3:0] press;
  logic       event_any;
  logic       invalid;
  logic [1:0] note;

  assign press     = prev_reg & ~sync2_reg;
  assign event_any = |press;
  assign invalid   = event_any & ~$onehot(press);

  always_comb begin
    note = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (press[b]) note = 2'(b);
    end
  end

  // ---------------------------------------------------------------------
  // Candidate evaluation
  // ---------------------------------------------------------------------
  state_t                state_reg;
  logic [NUM_SONGS-1:0]  cand_reg;
  logic [NUM_SONGS-1:0]  cand_next;
  logic [NUM_SONGS-1:0]  hit;
  logic [3:0]            pos_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [HOLD_W-1:0]     hold_cnt_reg;
  logic [MID_W-1:0]      hit_id;

  for (genvar gi = 0; gi < NUM_SONGS; gi++) begin : g_song
    logic [1:0] pat_note;
    logic [3:0] song_len;

    assign song_len = SONG_LEN[gi*4 +: 4];

    // Constant-index mux keeps every select in range for any pos value.
    always_comb begin
      pat_note = 2'd0;
      for (int j = 0; j < MAX_LEN; j++) begin
        if (pos_reg == 4'(j)) pat_note = SONG_PAT[(gi*MAX_LEN + j)*2 +: 2];
      end
    end

    assign cand_next[gi] = cand_reg[gi] & ~invalid & (note == pat_note) &
                           (pos_reg < song_len);
    // This note completes song gi.
    assign hit[gi] = cand_next[gi] & (song_len == pos_reg + 4'd1);
  end

  // Lowest-numbered completed song wins, so a prefix song beats a longer one.
  always_comb begin
    hit_id = '0;
    for (int s = NUM_SONGS - 1; s >= 0; s--) begin
      if (hit[s]) hit_id = MID_W'(s);
    end
  end

  // ---------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cand_reg     <= '1;
      pos_reg      <= 4'd0;
      to_cnt_reg   <= '0;
      hold_cnt_reg <= '0;
      match_id     <= '0;
      note_count   <= 4'd0;
      busy         <= 1'b0;
      match        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, LISTEN: begin
          if (event_any) begin
            // An event in the timeout cycle is still processed as an event.
            to_cnt_reg <= '0;
            if (|hit) begin
              state_reg  <= MATCH;
              match_id   <= hit_id;
              note_count <= pos_reg + 4'd1;
              busy       <= 1'b0;
              match      <= 1'b1;
            end else if (cand_next == '0) begin
              state_reg <= FAIL;
              busy      <= 1'b0;
              fail      <= 1'b1;
            end else begin
              state_reg  <= LISTEN;
              cand_reg   <= cand_next;
              pos_reg    <= pos_reg + 4'd1;
              note_count <= pos_reg + 4'd1;
              busy       <= 1'b1;
            end
          end else if (state_reg == LISTEN) begin
            if (to_cnt_reg == TO_LAST) begin
              state_reg <= FAIL;
              busy      <= 1'b0;
              fail      <= 1'b1;
            end else begin
              to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
          end
        end

        MATCH, FAIL: begin
          // Events are discarded here; only the hold counter advances.
          if (hold_cnt_reg == HOLD_LAST) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            cand_reg     <= '1;
            pos_reg      <= 4'd0;
            to_cnt_reg   <= '0;
            note_count   <= 4'd0;
            match        <= 1'b0;
            fail         <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          match     <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
